// File: rtl/instr_sequencer_pkg.sv
// Shared types and opcode constants for the instruction sequencer and its executors.
package instr_sequencer_pkg;

    // Opcode classes; CLS_NOP doubles as the idle/reset value of the latched class.
    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_LD   = 3'd1,
        CLS_MOV  = 3'd2,
        CLS_ALU  = 3'd3,
        CLS_HALT = 3'd4
    } op_class_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FA    = 4'd1,
        ST_FR    = 4'd2,
        ST_FI    = 4'd3,
        ST_DEC   = 4'd4,
        ST_DSP   = 4'd5,
        ST_WT    = 4'd6,
        ST_HALT  = 4'd7,
        ST_FAULT = 4'd8
    } seq_state_e;

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_LD_LO  = 4'b0001;
    localparam logic [3:0] OP_LD_HI  = 4'b0011;
    localparam logic [3:0] OP_MOV_LO = 4'b0100;
    localparam logic [3:0] OP_MOV_HI = 4'b0111;
    localparam logic [3:0] OP_HALT   = 4'b1000;
    localparam logic [3:0] OP_ALU_LO = 4'b1001;
    localparam logic [3:0] OP_ALU_HI = 4'b1111;

    // Map a 4-bit opcode onto the executor class that owns it.
    function automatic op_class_e decode_op(input logic [3:0] op);
        op_class_e cls;
        cls = CLS_NOP;
        case (op) inside
            OP_NOP:                 cls = CLS_NOP;
            [OP_LD_LO:OP_LD_HI]:    cls = CLS_LD;
            [OP_MOV_LO:OP_MOV_HI]:  cls = CLS_MOV;
            OP_HALT:                cls = CLS_HALT;
            [OP_ALU_LO:OP_ALU_HI]:  cls = CLS_ALU;
            default:                cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Fetch bus and executor start/done handshake between the sequencer and its neighbours.
interface instr_sequencer_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        PC_out;
    logic        MAR_in;
    logic        mem_rd;
    logic        IR_in;
    logic        PC_inc;
    logic        alu_start;
    logic        mov_start;
    logic        ld_start;
    logic        alu_done;
    logic        mov_done;
    logic        ld_done;

    // Sequencer side.
    modport master (
        input  instr, mem_ready, alu_done, mov_done, ld_done,
        output PC_out, MAR_in, mem_rd, IR_in, PC_inc,
        output alu_start, mov_start, ld_start
    );

    // Memory / executor side.
    modport slave (
        output instr, mem_ready, alu_done, mov_done, ld_done,
        input  PC_out, MAR_in, mem_rd, IR_in, PC_inc,
        input  alu_start, mov_start, ld_start
    );
endinterface

// File: rtl/instr_sequencer_watchdog.sv
// Dispatch watchdog: cleared while dispatching, counts up while waiting for done,
// and flags expiry once the count reaches TIMEOUT-1.
module seq_watchdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Count up while enabled; hold at the last value so the count never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches, decodes and dispatches one instruction at a time
// to the ALU, move or load executor, with a watchdog on every dispatch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | stopped at an instruction boundary, waiting for run
// FA       | fetch address: PC onto bus, MAR loads
// FR       | fetch read: memory read until mem_ready
// FI       | fetch into IR, PC increments
// DEC      | decode opcode; NOP retires here, HALT stops here
// DSP      | one-cycle start pulse to the latched executor, watchdog cleared
// WT       | wait for the dispatched executor's done, watchdog running
// HALT     | terminal, HALT opcode executed
// FAULT    | terminal, executor never answered
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    instr_sequencer_if.master   bus,
    output logic                busy,
    output logic                halted,
    output logic                fault,
    output logic [15:0]         instr_cnt
);

    seq_state_e state;
    seq_state_e state_nxt;
    op_class_e  cls;
    op_class_e  dec_cls;
    logic       done_sel;
    logic       retire;
    logic       wd_clr;
    logic       wd_en;
    logic       wd_expired;
    logic       unused_instr_bits;

    // Only the opcode nibble matters here; operand bits belong to the executors.
    assign unused_instr_bits = ^bus.instr[11:0];
    assign dec_cls           = decode_op(bus.instr[15:12]);
    assign wd_clr            = (state == ST_DSP);
    assign wd_en             = (state == ST_WT);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Select the done line of the dispatched executor; all others are ignored.
    always_comb begin
        done_sel = 1'b0;
        case (cls)
            CLS_ALU: done_sel = bus.alu_done;
            CLS_MOV: done_sel = bus.mov_done;
            CLS_LD:  done_sel = bus.ld_done;
            default: done_sel = 1'b0;
        endcase
    end

    // Next-state and retire decision; run is only looked at in IDLE and on retire.
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            ST_IDLE:  if (run) state_nxt = ST_FA;
            ST_FA:    state_nxt = ST_FR;
            ST_FR:    if (bus.mem_ready) state_nxt = ST_FI;
            ST_FI:    state_nxt = ST_DEC;
            ST_DEC: begin
                case (dec_cls)
                    CLS_NOP:  retire    = 1'b1;
                    CLS_HALT: state_nxt = ST_HALT;
                    default:  state_nxt = ST_DSP;
                endcase
            end
            ST_DSP:   state_nxt = ST_WT;
            ST_WT: begin
                // done in the expiry cycle still retires the instruction
                if (done_sel) begin
                    retire = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_HALT:  state_nxt = ST_HALT;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
        if (retire) begin
            state_nxt = run ? ST_FA : ST_IDLE;
        end
    end

    // State, latched class, retire counter and all outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cls           <= CLS_NOP;
            instr_cnt     <= '0;
            bus.PC_out    <= 1'b0;
            bus.MAR_in    <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.IR_in     <= 1'b0;
            bus.PC_inc    <= 1'b0;
            bus.alu_start <= 1'b0;
            bus.mov_start <= 1'b0;
            bus.ld_start  <= 1'b0;
            busy          <= 1'b0;
            halted        <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state <= state_nxt;
            // Class is frozen for DSP/WT so later instr changes cannot redirect the handshake.
            if ((state == ST_DEC) && (state_nxt == ST_DSP)) begin
                cls <= dec_cls;
            end
            if (retire) begin
                instr_cnt <= instr_cnt + 16'd1;
            end
            bus.PC_out    <= (state_nxt == ST_FA);
            bus.MAR_in    <= (state_nxt == ST_FA);
            bus.mem_rd    <= (state_nxt == ST_FR);
            bus.IR_in     <= (state_nxt == ST_FI);
            bus.PC_inc    <= (state_nxt == ST_FI);
            // DSP is only entered from DEC, so dec_cls is the class being latched.
            bus.alu_start <= (state_nxt == ST_DSP) && (dec_cls == CLS_ALU);
            bus.mov_start <= (state_nxt == ST_DSP) && (dec_cls == CLS_MOV);
            bus.ld_start  <= (state_nxt == ST_DSP) && (dec_cls == CLS_LD);
            busy          <= (state_nxt != ST_IDLE) && (state_nxt != ST_HALT)
                             && (state_nxt != ST_FAULT);
            halted        <= (state_nxt == ST_HALT);
            fault         <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// instruction streams checked against a cycle-budget model of each instruction.
module tb_instr_sequencer;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [15:0] instr_cnt;

    instr_sequencer_if bus();

    instr_sequencer #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .bus       (bus),
        .busy      (busy),
        .halted    (halted),
        .fault     (fault),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_cnt = '0;

    // Class numbers used by the model: 0 NOP, 1 LOAD, 2 MOVE, 3 ALU, 4 HALT.
    function automatic int model_class(input logic [15:0] ins);
        int op;
        op = int'(ins[15:12]);
        if (op == 0) return 0;
        if (op <= 3) return 1;
        if (op <= 7) return 2;
        if (op == 8) return 4;
        return 3;
    endfunction

    function automatic logic rbit();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    function automatic logic [10:0] outs_vec();
        return {bus.PC_out, bus.MAR_in, bus.mem_rd, bus.IR_in, bus.PC_inc,
                bus.alu_start, bus.mov_start, bus.ld_start, busy, halted, fault};
    endfunction

    task automatic apply_reset();
        rst           = 1'b0;
        run           = 1'b0;
        bus.instr     = '0;
        bus.mem_ready = 1'b0;
        bus.alu_done  = 1'b0;
        bus.mov_done  = 1'b0;
        bus.ld_done   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_cnt = '0;
    endtask

    // Step until the sequencer shows FA; returns the number of cycles taken.
    task automatic wait_fa(input string tag, output int n);
        n = 0;
        while (!bus.PC_out && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.PC_out) begin
            checks++;
            $display("FAIL %s: no fetch start within 10 cycles", tag);
        end
    endtask

    // Run one non-HALT instruction starting from an observed FA cycle. Memory answers
    // after rdy_wait extra FR cycles, the dispatched executor answers in WT cycle
    // done_wt; all other done lines (and this one outside WT) carry random noise.
    task automatic exec_one(input string tag, input logic [15:0] ins, input int rdy_wait,
                            input int done_wt, input bit drop_run);
        int c, cyc, kst, rd_n, ir_n, n_alu, n_mov, n_ld, exp_cyc;
        bit ended, ready_given, ir_early;
        c = model_class(ins);
        bus.instr = ins;
        cyc = 0; kst = -1; rd_n = 0; ir_n = 0; n_alu = 0; n_mov = 0; n_ld = 0;
        ended = 1'b0; ready_given = 1'b0; ir_early = 1'b0;
        while (!ended && cyc < 400) begin
            if (bus.mem_rd) rd_n++;
            if (bus.IR_in) begin
                ir_n++;
                if (!ready_given) ir_early = 1'b1;
            end
            if (bus.alu_start) n_alu++;
            if (bus.mov_start) n_mov++;
            if (bus.ld_start)  n_ld++;
            if (bus.alu_start || bus.mov_start || bus.ld_start) kst = 0;
            else if (kst >= 0) kst++;
            if (drop_run && kst == 1) run = 1'b0;
            if (bus.mem_rd) begin
                bus.mem_ready = (rd_n > rdy_wait);
                if (rd_n > rdy_wait) ready_given = 1'b1;
            end else begin
                bus.mem_ready = rbit();
            end
            bus.alu_done = rbit();
            bus.mov_done = rbit();
            bus.ld_done  = rbit();
            if (kst >= 1) begin
                case (c)
                    1: bus.ld_done  = (kst == done_wt);
                    2: bus.mov_done = (kst == done_wt);
                    3: bus.alu_done = (kst == done_wt);
                    default: ;
                endcase
            end
            @(negedge clk);
            cyc++;
            if (bus.PC_out || !busy) ended = 1'b1;
        end
        bus.alu_done = 1'b0;
        bus.mov_done = 1'b0;
        bus.ld_done  = 1'b0;
        if (!ended) begin
            checks++;
            $display("FAIL %s: instruction did not finish within 400 cycles", tag);
        end
        exp_cyc = (c == 0) ? 4 + rdy_wait : 5 + rdy_wait + done_wt;
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (cyc !== exp_cyc) $display("FAIL %s cycles: got %0d expected %0d", tag, cyc, exp_cyc);
        else passes++;
        checks++;
        if (instr_cnt !== exp_cnt)
            $display("FAIL %s instr_cnt: got %h expected %h", tag, instr_cnt, exp_cnt);
        else passes++;
        checks++;
        if (n_alu !== ((c == 3) ? 1 : 0) || n_mov !== ((c == 2) ? 1 : 0) || n_ld !== ((c == 1) ? 1 : 0))
            $display("FAIL %s starts: got alu=%0d mov=%0d ld=%0d for class %0d", tag, n_alu, n_mov, n_ld, c);
        else passes++;
        checks++;
        if (rd_n !== rdy_wait + 1) $display("FAIL %s mem_rd cycles: got %0d expected %0d", tag, rd_n, rdy_wait + 1);
        else passes++;
        checks++;
        if (ir_n !== 1 || ir_early) $display("FAIL %s IR_in: got %0d cycles early=%0d expected 1 after ready", tag, ir_n, ir_early);
        else passes++;
        if (drop_run) begin
            checks++;
            if (busy !== 1'b0 || bus.PC_out !== 1'b0)
                $display("FAIL %s stop: got busy=%b PC_out=%b expected idle", tag, busy, bus.PC_out);
            else passes++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        run = 1'b1;
        bus.instr = 16'h9000; bus.mem_ready = 1'b1;
        bus.alu_done = 1'b1; bus.mov_done = 1'b1; bus.ld_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs_vec() !== 11'd0) $display("FAIL reset outputs: got %b expected all zero", outs_vec());
        else passes++;
        checks++;
        if (instr_cnt !== 16'd0) $display("FAIL reset instr_cnt: got %h expected 0000", instr_cnt);
        else passes++;
        apply_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (outs_vec() !== 11'd0) $display("FAIL idle without run: got %b expected all zero", outs_vec());
        else passes++;
    endtask

    task automatic test_nop_stream();
        int n;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        wait_fa("nop_start", n);
        checks++;
        if (n !== 1) $display("FAIL idle_to_fa: got %0d cycles expected 1", n);
        else passes++;
        for (int i = 0; i < 3; i++) exec_one("nop_stream", 16'h0000, 0, 0, 1'b0);
        checks++;
        if (instr_cnt !== 16'd3) $display("FAIL nop_stream count: got %h expected 0003", instr_cnt);
        else passes++;
    endtask

    task automatic test_alu();
        exec_one("alu_9042", 16'h9042, 0, 3, 1'b0);
    endtask

    task automatic test_mem_wait();
        exec_one("mem_wait", 16'h0000, 5, 0, 1'b0);
        exec_one("mem_wait_ld", 16'h3abc, 2, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [3:0]  op;
        int          dw;
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h8) op = 4'h0;
            ins = 16'($urandom);
            ins[15:12] = op;
            dw = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(1, 8));
            exec_one("random", ins, int'($urandom_range(0, 3)), dw, 1'b0);
        end
    endtask

    task automatic test_timeout_boundary();
        exec_one("done_at_limit", 16'h2abc, 0, TIMEOUT, 1'b0);
        exec_one("done_before_limit", 16'hf123, 1, TIMEOUT - 1, 1'b0);
    endtask

    task automatic test_drop_run();
        exec_one("drop_run", 16'h5123, 1, 2, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.PC_out !== 1'b0 || instr_cnt !== exp_cnt)
            $display("FAIL drop_run idle: got busy=%b PC_out=%b cnt=%h expected 0 0 %h", busy, bus.PC_out, instr_cnt, exp_cnt);
        else passes++;
    endtask

    task automatic test_wrap();
        int n;
        force dut.instr_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.instr_cnt;
        exp_cnt = 16'hFFFF;
        run = 1'b1;
        wait_fa("wrap_start", n);
        exec_one("wrap_nop", 16'h0000, 0, 0, 1'b0);
    endtask

    task automatic test_watchdog_fault();
        int k, n, bad;
        bit got;
        bus.instr = 16'h4000;
        k = -1; n = 0; got = 1'b0;
        while (!got && n < 100) begin
            if (bus.mov_start) k = 0;
            else if (k >= 0) k++;
            if (k == TIMEOUT) begin
                checks++;
                if (fault !== 1'b0 || busy !== 1'b1)
                    $display("FAIL wt_last_cycle: got fault=%b busy=%b expected 0 1", fault, busy);
                else passes++;
            end
            if (k == TIMEOUT + 1) begin
                got = 1'b1;
                checks++;
                if (fault !== 1'b1 || busy !== 1'b0)
                    $display("FAIL fault_entry: got fault=%b busy=%b expected 1 0", fault, busy);
                else passes++;
            end else begin
                bus.mem_ready = bus.mem_rd;
                bus.alu_done  = (k >= 1);
                bus.ld_done   = rbit();
                bus.mov_done  = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        if (!got) begin
            checks++;
            $display("FAIL fault_entry: no fault within 100 cycles");
        end
        bus.alu_done = 1'b0;
        bus.ld_done  = 1'b0;
        bad = 0;
        repeat (6) begin
            bus.mov_done = 1'b1;
            run = rbit();
            @(negedge clk);
            if (!fault || busy || bus.PC_out) bad++;
        end
        bus.mov_done = 1'b0;
        checks++;
        if (bad !== 0) $display("FAIL fault_terminal: got %0d bad cycles expected 0", bad);
        else passes++;
        checks++;
        if (instr_cnt !== exp_cnt) $display("FAIL fault_count: got %h expected %h", instr_cnt, exp_cnt);
        else passes++;
        apply_reset();
    endtask

    task automatic test_halt();
        int n, starts, bad;
        run = 1'b1;
        wait_fa("halt_start", n);
        bus.instr = 16'h8000;
        n = 0; starts = 0;
        while (!halted && n < 20) begin
            bus.mem_ready = 1'b1;
            @(negedge clk);
            n++;
            if (bus.alu_start || bus.mov_start || bus.ld_start) starts++;
        end
        checks++;
        if (n !== 4 || starts !== 0) $display("FAIL halt_entry: got %0d cycles %0d starts expected 4 0", n, starts);
        else passes++;
        bad = 0;
        repeat (8) begin
            run = rbit();
            @(negedge clk);
            if (!halted || busy || bus.PC_out) bad++;
        end
        checks++;
        if (bad !== 0 || instr_cnt !== exp_cnt)
            $display("FAIL halt_terminal: got %0d bad cycles cnt=%h expected 0 %h", bad, instr_cnt, exp_cnt);
        else passes++;
        rst = 1'b0;
        #2;
        checks++;
        if (outs_vec() !== 11'd0 || instr_cnt !== 16'd0)
            $display("FAIL halt_reset: got outs=%b cnt=%h expected zeros", outs_vec(), instr_cnt);
        else passes++;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        run = 1'b1;
        bus.mem_ready = 1'b1;
        bus.instr = 16'h9000;
        wait_fa("mid_start", n);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (outs_vec() !== 11'd0 || instr_cnt !== 16'd0)
            $display("FAIL reset_mid: got outs=%b cnt=%h expected zeros", outs_vec(), instr_cnt);
        else passes++;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_alu();
        test_mem_wait();
        test_random();
        test_timeout_boundary();
        test_drop_run();
        test_wrap();
        test_watchdog_fault();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
